core_exu_mdu: RTL and testbench

Parametrised multi-cycle M-extension execution unit for the RV64IM pipeline. It sits beside the single-cycle ALU in the execute stage and implements MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and their W forms. It uses an iterative datapath and a valid/ready handshake. While an operation is in flight, `busy_o` stalls the front of the pipeline via the hazard detection unit.

---
 rtl/core_exu_mdu.sv | 210 +++++++++++++++++++++
 tb/tb_core_exu_mdu.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_exu_mdu.sv
// Iterative RV64 M-extension unit: shift-add multiplier and restoring divider
// behind a valid/ready handshake, with W-form handling and early-out special divides.
module core_exu_mdu #(
  parameter int XLEN       = 64,
  parameter int MUL_UNROLL = 4,
  parameter int DIV_UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      funct3_i,
  input  logic            w_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rsd_idx_i,
  input  logic            kill_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rsd_idx_o,
  output logic            busy_o
);

  localparam int PW = 2 * XLEN;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [6:0] N_MUL_D = 7'(XLEN / MUL_UNROLL);
  localparam logic [6:0] N_MUL_W = 7'(32 / MUL_UNROLL);
  localparam logic [6:0] N_DIV_D = 7'(XLEN / DIV_UNROLL);
  localparam logic [6:0] N_DIV_W = 7'(32 / DIV_UNROLL);

  localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, {31{1'b0}}};

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    return {{(XLEN-32){x[31]}}, x};
  endfunction

  function automatic logic [XLEN-1:0] ext_op(input logic [XLEN-1:0] x, input logic w,
                                             input logic sgn);
    if (!w)
      return x;
    else if (sgn)
      return sext32(x[31:0]);
    else
      return {{(XLEN-32){1'b0}}, x[31:0]};
  endfunction

  function automatic logic [XLEN-1:0] fix_w(input logic [XLEN-1:0] x, input logic w);
    return w ? sext32(x[31:0]) : x;
  endfunction

  logic [1:0]      state_q, state_d;
  logic [6:0]      cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  logic            w_q, w_d;
  logic            neg_q, neg_d;
  logic [4:0]      rsd_q, rsd_d;
  logic [PW-1:0]   mcand_q, mcand_d;   // multiplicand, or divisor in the low half
  logic [XLEN-1:0] shreg_q, shreg_d;   // multiplier, or dividend shifting into quotient
  logic [PW-1:0]   acc_q, acc_d;       // product, or partial remainder in the low bits
  logic [XLEN-1:0] res_q, res_d;

  logic            is_div_i, sgn_a, sgn_b, a_neg, b_neg;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] a_eff, b_eff, a_mag, b_mag, spec_raw;
  logic [6:0]      cnt_init;

  assign is_div_i = funct3_i[2];
  assign sgn_a    = is_div_i ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11);
  assign sgn_b    = is_div_i ? ~funct3_i[0] : ~funct3_i[1];
  assign a_eff    = ext_op(rs1_data_i, w_i, sgn_a);
  assign b_eff    = ext_op(rs2_data_i, w_i, sgn_b);
  assign a_neg    = sgn_a & a_eff[XLEN-1];
  assign b_neg    = sgn_b & b_eff[XLEN-1];
  assign a_mag    = a_neg ? -a_eff : a_eff;
  assign b_mag    = b_neg ? -b_eff : b_eff;

  assign div_zero = is_div_i & (b_eff == {XLEN{1'b0}});
  assign div_ovf  = is_div_i & sgn_a & (a_eff == (w_i ? MIN_W : MIN_D)) &
                    (b_eff == {XLEN{1'b1}});
  assign spec_raw = div_zero ? (funct3_i[1] ? a_eff : {XLEN{1'b1}})
                             : (funct3_i[1] ? {XLEN{1'b0}} : a_eff);
  assign cnt_init = is_div_i ? (w_i ? N_DIV_W : N_DIV_D) : (w_i ? N_MUL_W : N_MUL_D);

  logic [PW-1:0]   acc_mul, prod_s;
  logic [XLEN:0]   rem_t;
  logic [XLEN-1:0] quo_t, mul_res, div_sel, div_res, calc_res;

  // One CALC step: the multiplier retires MUL_UNROLL bits, the divider DIV_UNROLL bits.
  always_comb begin
    acc_mul = acc_q + mcand_q * PW'(shreg_q[MUL_UNROLL-1:0]);
    rem_t   = acc_q[XLEN:0];
    quo_t   = shreg_q;
    for (int i = 0; i < DIV_UNROLL; i++) begin
      rem_t = {rem_t[XLEN-1:0], quo_t[XLEN-1]};
      quo_t = {quo_t[XLEN-2:0], 1'b0};
      if (rem_t >= {1'b0, mcand_q[XLEN-1:0]}) begin
        rem_t    = rem_t - {1'b0, mcand_q[XLEN-1:0]};
        quo_t[0] = 1'b1;
      end
    end
  end

  assign prod_s   = neg_q ? -acc_mul : acc_mul;
  assign mul_res  = (f3_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[PW-1:XLEN];
  assign div_sel  = f3_q[1] ? rem_t[XLEN-1:0] : quo_t;
  assign div_res  = neg_q ? -div_sel : div_sel;
  assign calc_res = fix_w(f3_q[2] ? div_res : mul_res, w_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    w_d     = w_q;
    neg_d   = neg_q;
    rsd_d   = rsd_q;
    mcand_d = mcand_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i && !kill_i) begin
          f3_d  = funct3_i;
          w_d   = w_i;
          rsd_d = rsd_idx_i;
          neg_d = (is_div_i & funct3_i[1]) ? a_neg : (a_neg ^ b_neg);
          if (div_zero || div_ovf) begin
            res_d   = fix_w(spec_raw, w_i);
            state_d = S_DONE;
          end else begin
            acc_d   = '0;
            cnt_d   = cnt_init;
            state_d = S_CALC;
            if (is_div_i) begin
              mcand_d = {{XLEN{1'b0}}, b_mag};
              // W divides start from bit 31, so park the 32-bit dividend at the top.
              shreg_d = w_i ? {a_mag[31:0], 32'b0} : a_mag;
            end else begin
              mcand_d = {{XLEN{1'b0}}, a_mag};
              shreg_d = b_mag;
            end
          end
        end
      end
      S_CALC: begin
        if (kill_i) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 7'd1;
          if (f3_q[2]) begin
            acc_d   = PW'(rem_t);
            shreg_d = quo_t;
          end else begin
            acc_d   = acc_mul;
            mcand_d = mcand_q << MUL_UNROLL;
            shreg_d = shreg_q >> MUL_UNROLL;
          end
          if (cnt_q == 7'd1) begin
            res_d   = calc_res;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (kill_i || ready_i)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      w_q     <= 1'b0;
      neg_q   <= 1'b0;
      rsd_q   <= '0;
      mcand_q <= '0;
      shreg_q <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      w_q     <= w_d;
      neg_q   <= neg_d;
      rsd_q   <= rsd_d;
      mcand_q <= mcand_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  assign ready_o   = (state_q == S_IDLE);
  assign valid_o   = (state_q == S_DONE);
  assign busy_o    = ~ready_o;
  assign result_o  = res_q;
  assign rsd_idx_o = rsd_q;

endmodule

// File: tb/tb_core_exu_mdu.sv
// Bench for core_exu_mdu: vector table through a scoreboard queue, then
// backpressure, kill and asynchronous-reset sequences.
`timescale 1ns/1ps
module tb_core_exu_mdu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [2:0]  funct3_i = '0;
  logic        w_i = 1'b0;
  logic [63:0] rs1_data_i = '0;
  logic [63:0] rs2_data_i = '0;
  logic [4:0]  rsd_idx_i = '0;
  logic        kill_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [63:0] result_o;
  logic [4:0]  rsd_idx_o;
  logic        busy_o;

  core_exu_mdu #(.XLEN(64), .MUL_UNROLL(4), .DIV_UNROLL(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .funct3_i   (funct3_i),
    .w_i        (w_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .rsd_idx_i  (rsd_idx_i),
    .kill_i     (kill_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .result_o   (result_o),
    .rsd_idx_o  (rsd_idx_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  idx;
    int          lat;
  } sb_t;

  localparam int NV = 25;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

  vec_t vecs [NV];
  sb_t  sb_q [$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (valid_o !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Called on a negedge with the unit idle; returns on the negedge after the handshake.
  task automatic do_op(input vec_t v, input logic [4:0] idx, input string name);
    sb_t e;
    int  lat;
    valid_i    = 1'b1;
    ready_i    = 1'b1;
    funct3_i   = v.f3;
    w_i        = v.w;
    rs1_data_i = v.a;
    rs2_data_i = v.b;
    rsd_idx_i  = idx;
    e.res = v.exp;
    e.idx = idx;
    e.lat = v.lat;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    valid_i    = 1'b0;
    funct3_i   = 3'($urandom);
    w_i        = 1'($urandom);
    rs1_data_i = {$urandom(), $urandom()};
    rs2_data_i = {$urandom(), $urandom()};
    rsd_idx_i  = 5'($urandom);
    if (v.lat > 1)
      chk({name, " busy/ready in calc"}, {62'b0, busy_o, ready_o}, 64'h2);
    wait_valid(lat);
    chk({name, " valid"}, 64'(valid_o), 64'h1);
    e = sb_q.pop_front();
    chk({name, " result"}, result_o, e.res);
    chk({name, " idx"}, 64'(rsd_idx_o), 64'(e.idx));
    chk({name, " latency"}, 64'(lat), 64'(e.lat));
    @(negedge clk);
    chk({name, " idle after handshake"}, {62'b0, ready_o, valid_o}, 64'h2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    sb_t  e;
    int   lat;
    logic seen;
    vec_t kv;

    vecs[0]  = '{3'd0, 1'b0, 64'h1_0000, 64'h1_0000, 64'h1_0000_0000, 17};
    vecs[1]  = '{3'd1, 1'b0, MIN, 64'd2, ONES, 17};
    vecs[2]  = '{3'd3, 1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 17};
    vecs[3]  = '{3'd2, 1'b0, ONES, 64'd2, ONES, 17};
    vecs[4]  = '{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[5]  = '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 65};
    vecs[6]  = '{3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65};
    vecs[7]  = '{3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 65};
    vecs[8]  = '{3'd4, 1'b0, 64'd5, 64'd0, ONES, 1};
    vecs[9]  = '{3'd6, 1'b0, 64'd5, 64'd0, 64'd5, 1};
    vecs[10] = '{3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
    vecs[11] = '{3'd6, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1};
    vecs[12] = '{3'd0, 1'b1, 64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0003,
                 64'h0000_0000_7FFF_FFFD, 9};
    vecs[13] = '{3'd0, 1'b1, 64'h0000_0000_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1, 9};
    vecs[14] = '{3'd5, 1'b1, 64'hAAAA_AAAA_FFFF_FFFF, 64'h5555_5555_0000_0001, ONES, 33};
    vecs[15] = '{3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, ONES, 33};
    vecs[16] = '{3'd4, 1'b1, 64'd100, 64'd7, 64'd14, 33};
    vecs[17] = '{3'd4, 1'b0, MIN, ONES, MIN, 1};
    vecs[18] = '{3'd6, 1'b0, MIN, ONES, 64'd0, 1};
    vecs[19] = '{3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 17};
    vecs[20] = '{3'd5, 1'b0, ONES, 64'd16, 64'h0FFF_FFFF_FFFF_FFFF, 65};
    vecs[21] = '{3'd7, 1'b1, 64'h8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, 1};
    vecs[22] = '{3'd3, 1'b0, 64'h1_0000_0000, 64'h1_0000_0000, 64'd1, 17};
    vecs[23] = '{3'd2, 1'b0, ONES, MIN, ONES, 17};
    vecs[24] = '{3'd1, 1'b0, ONES, MIN, 64'd0, 17};

    // Reset state, during and after reset
    repeat (2) @(negedge clk);
    chk("reset flags", {61'b0, ready_o, valid_o, busy_o}, 64'h4);
    chk("reset result", result_o, 64'd0);
    chk("reset idx", 64'(rsd_idx_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset flags", {61'b0, ready_o, valid_o, busy_o}, 64'h4);

    for (int i = 0; i < NV; i++)
      do_op(vecs[i], 5'(i + 1), $sformatf("vec%0d", i));

    // Backpressure: hold result in DONE for 10 cycles
    valid_i = 1'b1; ready_i = 1'b0;
    funct3_i = 3'd0; w_i = 1'b0; rs1_data_i = 64'd123; rs2_data_i = 64'd456; rsd_idx_i = 5'd9;
    e.res = 64'd56088; e.idx = 5'd9; e.lat = 17;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0; rs1_data_i = '0; rs2_data_i = '0;
    wait_valid(lat);
    chk("bp latency", 64'(lat), 64'd17);
    for (int k = 0; k < 10; k++) begin
      chk("bp flags held", {61'b0, valid_o, busy_o, ready_o}, 64'h6);
      chk("bp result held", result_o, 64'd56088);
      @(negedge clk);
    end
    e = sb_q.pop_front();
    chk("bp result", result_o, e.res);
    chk("bp idx", 64'(rsd_idx_o), 64'(e.idx));
    ready_i = 1'b1;
    @(negedge clk);
    chk("bp release idle", {61'b0, ready_o, valid_o, busy_o}, 64'h4);

    // Kill in IDLE blocks accept
    valid_i = 1'b1; kill_i = 1'b1;
    funct3_i = 3'd4; rs1_data_i = 64'd50; rs2_data_i = 64'd5; rsd_idx_i = 5'd3;
    @(negedge clk);
    valid_i = 1'b0; kill_i = 1'b0;
    chk("kill in idle blocks accept", {62'b0, ready_o, busy_o}, 64'h2);

    // Kill in CALC cycle 5 of a DIV
    valid_i = 1'b1;
    funct3_i = 3'd4; w_i = 1'b0; rs1_data_i = 64'd1000; rs2_data_i = 64'd3; rsd_idx_i = 5'd7;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    repeat (4) @(negedge clk);
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    chk("kill -> idle", {61'b0, ready_o, valid_o, busy_o}, 64'h4);
    seen = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (valid_o === 1'b1) seen = 1'b1;
    end
    chk("killed op never valid", 64'(seen), 64'd0);
    kv = '{3'd0, 1'b1, 64'd7, 64'd9, 64'd63, 9};
    do_op(kv, 5'd11, "mulw after kill");

    // Asynchronous reset mid-CALC
    valid_i = 1'b1;
    funct3_i = 3'd4; w_i = 1'b0; rs1_data_i = 64'd1000; rs2_data_i = 64'd3; rsd_idx_i = 5'd21;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset flags", {61'b0, ready_o, valid_o, busy_o}, 64'h4);
    chk("async reset result", result_o, 64'd0);
    chk("async reset idx", 64'(rsd_idx_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    kv = '{3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65};
    do_op(kv, 5'd30, "divu after reset");

    chk("scoreboard drained", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
